// File: rtl/alu_forward_ctrl.sv
// -----------------------------------------------------------------------------
// alu_forward_ctrl
//
// Forwarding and load-use hazard controller for the semiMIPS five-stage
// pipeline. Destination tags of the instructions in EX, MEM and WB are tracked
// in three slots. From these tags and the instruction currently in ID the block
// derives:
//   * the ALU operand forwarding selects. They are computed while the consumer
//     sits in ID and registered, so they are valid while it occupies EX.
//   * the load-use stall and the ID/EX bubble request for the front end.
//   * a saturating count of stall cycles.
//
// Ports
//   clk          pipeline clock, all state updates on the rising edge
//   rst          asynchronous, active-high reset
//   id_valid     ID stage holds a real instruction
//   id_rs/id_rt  source register numbers of the ID instruction
//   id_use_rs/id_use_rt  ID instruction actually reads rs / rt
//   id_dest      destination register of the ID instruction
//   id_regwrite  ID instruction writes id_dest
//   id_memread   ID instruction is a load
//   flush        branch/jump redirect, squashes the ID instruction
//   fwd_a/fwd_b  operand mux selects: 00 register file, 10 EX/MEM ALU result,
//                01 MEM/WB writeback value (11 is never driven)
//   stall        hold PC and IF/ID this cycle (combinational)
//   bubble       ID/EX loads a NOP this cycle (combinational)
//   stall_cnt    saturating count of stall cycles
// -----------------------------------------------------------------------------
module alu_forward_ctrl #(
    parameter int RADDR = 5,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RADDR-1:0] id_rs,
    input  logic [RADDR-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [RADDR-1:0] id_dest,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall,
    output logic             bubble,
    output logic [CNTW-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,   // register file read data
        FWD_WB  = 2'b01,   // MEM/WB writeback value
        FWD_ALU = 2'b10    // EX/MEM ALU result
    } fwd_sel_t;

    // Tag information carried down the pipeline for one instruction.
    typedef struct packed {
        logic             valid;
        logic [RADDR-1:0] dest;
        logic             regwrite;
        logic             memread;
    } slot_t;

    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    slot_t    ex_slot;
    slot_t    mem_slot;
    slot_t    wb_slot;
    slot_t    id_entry;

    fwd_sel_t fwd_a_q;
    fwd_sel_t fwd_b_q;
    fwd_sel_t fwd_a_next;
    fwd_sel_t fwd_b_next;

    logic     load_use_rs;
    logic     load_use_rt;

    // A slot produces register r only if it really writes it; r0 is hardwired
    // to zero, so it is never a forwarding or stall source.
    function automatic logic produces(input slot_t s, input logic [RADDR-1:0] r);
        return s.valid && s.regwrite && (s.dest == r) && (r != '0);
    endfunction

    // Nearer producer wins. A load in EX has no ALU result to forward; that
    // case is covered by the stall, after which the load sits in MEM.
    function automatic fwd_sel_t select_src(
        input logic             used,
        input logic [RADDR-1:0] r,
        input slot_t            ex_s,
        input slot_t            mem_s
    );
        if (!used) begin
            return FWD_REG;
        end
        if (produces(ex_s, r) && !ex_s.memread) begin
            return FWD_ALU;
        end
        if (produces(mem_s, r)) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

    // -------------------------------------------------------------------------
    // Hazard detection
    // -------------------------------------------------------------------------
    assign load_use_rs = id_use_rs && produces(ex_slot, id_rs) && ex_slot.memread;
    assign load_use_rt = id_use_rt && produces(ex_slot, id_rt) && ex_slot.memread;

    // A redirect squashes the ID instruction, so its hazard is moot: flush wins.
    assign stall  = id_valid && !flush && (load_use_rs || load_use_rt);
    assign bubble = stall || flush || !id_valid;

    // -------------------------------------------------------------------------
    // Next EX slot and next forwarding selects
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        id_entry   = '0;
        fwd_a_next = FWD_REG;
        fwd_b_next = FWD_REG;

        // A bubbled slot is kept all-zero, not just marked invalid, so stale
        // tags never linger in the pipeline.
        if (!bubble) begin
            id_entry.valid    = 1'b1;
            id_entry.dest     = id_dest;
            id_entry.regwrite = id_regwrite;
            id_entry.memread  = id_memread;

            fwd_a_next = select_src(id_use_rs, id_rs, ex_slot, mem_slot);
            fwd_b_next = select_src(id_use_rt, id_rt, ex_slot, mem_slot);
        end
    end

    // -------------------------------------------------------------------------
    // Tag pipeline and registered selects
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_slot  <= '0;
            mem_slot <= '0;
            wb_slot  <= '0;
            fwd_a_q  <= FWD_REG;
            fwd_b_q  <= FWD_REG;
        end else begin
            // NOTE: non-blocking assignments let the slots shift as a true
            // pipeline; each slot loads its upstream neighbour's old value.
            ex_slot  <= id_entry;
            mem_slot <= ex_slot;
            wb_slot  <= mem_slot;
            fwd_a_q  <= fwd_a_next;
            fwd_b_q  <= fwd_b_next;
        end
    end

    assign fwd_a = fwd_a_q;
    assign fwd_b = fwd_b_q;

    // -------------------------------------------------------------------------
    // Stall performance counter, saturates at all-ones
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

    // -------------------------------------------------------------------------
    // Invariants. The WB slot only ages tags; the register file writes before
    // it reads, so WB producers never need forwarding. Its contents are kept
    // for debug and checked here together with the other slots.
    // -------------------------------------------------------------------------
    always @(posedge clk) begin
        if (!rst) begin
            assert (ex_slot.valid  || (ex_slot  == '0));
            assert (mem_slot.valid || (mem_slot == '0));
            assert (wb_slot.valid  || (wb_slot  == '0));
            assert (fwd_a_q != 2'b11);
            assert (fwd_b_q != 2'b11);
        end
    end

endmodule

// File: tb/tb_alu_forward_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_forward_ctrl
//
// Directed bench for alu_forward_ctrl. Each stimulus cycle pushes the outputs
// the DUT must show during that cycle into a scoreboard queue; a monitor pops
// one entry per cycle on the falling edge and compares. Expected values are
// hand-derived from the pipeline timing (registered selects lag ID by a cycle).
// -----------------------------------------------------------------------------
module tb_alu_forward_ctrl;

    localparam int RADDR = 5;
    localparam int CNTW  = 4;   // small so saturation is reachable quickly

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [RADDR-1:0] id_rs;
    logic [RADDR-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [RADDR-1:0] id_dest;
    logic             id_regwrite;
    logic             id_memread;
    logic             flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             stall;
    logic             bubble;
    logic [CNTW-1:0]  stall_cnt;

    alu_forward_ctrl #(.RADDR(RADDR), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .id_dest    (id_dest),
        .id_regwrite(id_regwrite),
        .id_memread (id_memread),
        .flush      (flush),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .stall      (stall),
        .bubble     (bubble),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]      fa;
        logic [1:0]      fb;
        logic            st;
        logic            bu;
        logic [CNTW-1:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  mon_e;
    string mon_n;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // One pipeline cycle: drive the ID instruction just after the rising edge
    // and queue what the DUT must present during this cycle.
    task automatic step(
        input string            name,
        input logic             v,
        input logic [RADDR-1:0] rs,
        input logic [RADDR-1:0] rt,
        input logic             urs,
        input logic             urt,
        input logic [RADDR-1:0] dest,
        input logic             rw,
        input logic             mr,
        input logic             fl,
        input logic [1:0]       fa,
        input logic [1:0]       fb,
        input logic             st,
        input logic             bu,
        input logic [CNTW-1:0]  cnt
    );
        @(posedge clk);
        #1;
        id_valid    = v;
        id_rs       = rs;
        id_rt       = rt;
        id_use_rs   = urs;
        id_use_rt   = urt;
        id_dest     = dest;
        id_regwrite = rw;
        id_memread  = mr;
        flush       = fl;
        exp_q.push_back('{fa: fa, fb: fb, st: st, bu: bu, cnt: cnt});
        name_q.push_back(name);
    endtask

    task automatic nop(input string name, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [CNTW-1:0] cnt);
        step(name, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, fa, fb, 1'b0, 1'b1, cnt);
    endtask

    task automatic idle_inputs();
        id_valid    = 1'b0;
        id_rs       = '0;
        id_rt       = '0;
        id_use_rs   = 1'b0;
        id_use_rt   = 1'b0;
        id_dest     = '0;
        id_regwrite = 1'b0;
        id_memread  = 1'b0;
        flush       = 1'b0;
    endtask

    // Monitor: one scoreboard entry per cycle, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_n = name_q.pop_front();
                check({mon_n, "/fwd_a"},     32'(fwd_a),     32'(mon_e.fa));
                check({mon_n, "/fwd_b"},     32'(fwd_b),     32'(mon_e.fb));
                check({mon_n, "/stall"},     32'(stall),     32'(mon_e.st));
                check({mon_n, "/bubble"},    32'(bubble),    32'(mon_e.bu));
                check({mon_n, "/stall_cnt"}, 32'(stall_cnt), 32'(mon_e.cnt));
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle_inputs();

        // Reset state, with an ID instruction that would look like a hazard.
        #2;
        id_valid  = 1'b1;
        id_rs     = 5'd5;
        id_use_rs = 1'b1;
        #1;
        check("reset/fwd_a",     32'(fwd_a),     0);
        check("reset/fwd_b",     32'(fwd_b),     0);
        check("reset/stall",     32'(stall),     0);
        check("reset/bubble",    32'(bubble),    0);
        check("reset/stall_cnt", 32'(stall_cnt), 0);
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        //    name        v  rs rt urs urt dest rw mr fl  fa     fb     st bu cnt
        // ALU dependency at distance 1
        step("alu_c0",    1, 1, 2, 1, 1,  3,  1, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        step("alu_c1",    1, 3, 2, 1, 1,  8,  1, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        nop ("alu_c2",                                 2'b10, 2'b00,       0);
        nop ("alu_c3",                                 2'b00, 2'b00,       0);

        // Distance-2 dependency on rt
        step("d2_c0",     1, 1, 2, 1, 1,  4,  1, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        nop ("d2_c1",                                  2'b00, 2'b00,       0);
        step("d2_c2",     1, 9, 4, 1, 1, 10,  1, 0, 0, 2'b00, 2'b00, 0, 0, 0);
        nop ("d2_c3",                                  2'b00, 2'b01,       0);
        nop ("d2_c4",                                  2'b00, 2'b00,       0);

        // Load-use: one stall, consumer held in ID, then MEM/WB forwarding
        step("lu_c0",     1, 1, 0, 1, 0,  5,  1, 1, 0, 2'b00, 2'b00, 0, 0, 0);
        step("lu_c1",     1, 5, 2, 1, 1, 11,  1, 0, 0, 2'b00, 2'b00, 1, 1, 0);
        step("lu_c2",     1, 5, 2, 1, 1, 11,  1, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        nop ("lu_c3",                                  2'b01, 2'b00,       1);
        nop ("lu_c4",                                  2'b00, 2'b00,       1);

        // Priority: two writers of r6, reader uses r6 as both rs and rt
        step("pr_c0",     1, 1, 2, 1, 1,  6,  1, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        step("pr_c1",     1, 1, 2, 1, 1,  6,  1, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        step("pr_c2",     1, 6, 6, 1, 1, 12,  1, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        nop ("pr_c3",                                  2'b10, 2'b10,       1);
        nop ("pr_c4",                                  2'b00, 2'b00,       1);

        // r0: a load to r0 followed by readers of r0 never stalls or forwards
        step("r0_c0",     1, 1, 2, 1, 0,  0,  1, 1, 0, 2'b00, 2'b00, 0, 0, 1);
        step("r0_c1",     1, 0, 0, 1, 1, 13,  1, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        step("r0_c2",     1, 0, 0, 1, 1, 13,  1, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        nop ("r0_c3",                                  2'b00, 2'b00,       1);
        nop ("r0_c4",                                  2'b00, 2'b00,       1);

        // Flush beats a load-use stall
        step("fl_c0",     1, 1, 0, 1, 0,  7,  1, 1, 0, 2'b00, 2'b00, 0, 0, 1);
        step("fl_c1",     1, 7, 7, 1, 1, 14,  1, 0, 1, 2'b00, 2'b00, 0, 1, 1);
        nop ("fl_c2",                                  2'b00, 2'b00,       1);
        nop ("fl_c3",                                  2'b00, 2'b00,       1);

        // Build up non-zero selects, then pulse reset between clock edges
        step("rs_c0",     1, 1, 2, 1, 1,  3,  1, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        step("rs_c1",     1, 3, 3, 1, 1, 14,  1, 0, 0, 2'b00, 2'b00, 0, 0, 1);
        nop ("rs_c2",                                  2'b10, 2'b10,       1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst/fwd_a",     32'(fwd_a),     0);
        check("async_rst/fwd_b",     32'(fwd_b),     0);
        check("async_rst/stall",     32'(stall),     0);
        check("async_rst/stall_cnt", 32'(stall_cnt), 0);
        #1;
        rst = 1'b0;
        step("rs_j0",     1, 3, 3, 1, 1, 13,  1, 0, 0, 2'b00, 2'b00, 0, 0, 0);

        // Back-to-back "lw r5, 0(r5)": stalls on every other cycle, and once
        // the counter reaches all-ones it must stay there.
        for (int k = 0; k <= 34; k++) begin
            int m;
            logic [CNTW-1:0] c;
            m = k / 2;
            c = (m > 15) ? CNTW'(15) : CNTW'(m);
            if (k % 2 == 1) begin
                step($sformatf("sat_k%0d", k), 1, 5, 0, 1, 0, 5, 1, 1, 0,
                     (m == 0) ? 2'b00 : 2'b01, 2'b00, 1, 1, c);
            end else begin
                step($sformatf("sat_k%0d", k), 1, 5, 0, 1, 0, 5, 1, 1, 0,
                     2'b00, 2'b00, 0, 0, c);
            end
        end

        // Let the monitor drain the scoreboard, bounded.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        check("scoreboard_drain", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_forward_ctrl.md
# alu_forward_ctrl

Forwarding and load-use hazard controller for the semiMIPS five-stage pipeline. It tracks destination tags of instructions in EX, MEM and WB. It produces the 2-bit select codes for the two ALU operand forwarding muxes and the stall/bubble controls for the front end. Select codes are registered so they are valid during the cycle the consuming instruction occupies EX.

## Interface
- DWIDTH-free block; parameter RADDR, default 5: register-address width.
- Parameter CNTW, default 16: width of the stall performance counter.
- clk  input  1  pipeline clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs, id_rt  input  RADDR  source register numbers of the ID instruction.
- id_use_rs, id_use_rt  input  1  ID instruction actually reads rs / rt.
- id_dest  input  RADDR  destination register of the ID instruction.
- id_regwrite  input  1  ID instruction writes id_dest.
- id_memread  input  1  ID instruction is a load.
- flush  input  1  branch/jump redirect; the ID instruction is squashed.
- fwd_a, fwd_b  output  2  select for operand A / B mux: 00 register data, 10 ALU result (EX/MEM), 01 MEM/WB writeback value.
- stall  output  1  hold PC and IF/ID register this cycle (combinational).
- bubble  output  1  ID/EX register loads a NOP this cycle (combinational).
- stall_cnt  output  CNTW  saturating count of stall cycles.

## Operation
- Internal slots EX, MEM, WB each hold {valid, dest, regwrite, memread}. Every cycle: WB<=MEM, MEM<=EX, EX<=ID-entry. ID-entry is the ID instruction, or invalid when bubble=1 or id_valid=0.
- A slot is a producer for register r only if valid & regwrite & dest==r & r!=0. Register 0 is never forwarded or stalled on.
- Load-use: stall=1 when id_valid & !flush & EX slot is a producer with memread=1 for id_rs (id_use_rs) or id_rt (id_use_rt). Otherwise stall=0.
- bubble = stall | flush | !id_valid.
- Next fwd_a (computed in ID, registered into EX alignment):
  - 10 if the EX slot produces id_rs and is not a load.
  - else 01 if the MEM slot produces id_rs.
  - else 00.
  - Nearer producer wins.
  - fwd_b is the same rule using id_rt.
  - When id_use_x=0 or bubble=1, the registered code is 00.
- Code 11 is never driven.
- WB-slot producers need no forwarding. The register file writes before reading in the same cycle; the WB slot exists only for tag aging and debug.
- stall_cnt increments by 1 each cycle stall=1 and holds at all-ones.

## Timing
- Reset (async, immediate): all slots invalid, fwd_a=fwd_b=00, stall_cnt=0. With rst asserted, stall reflects only invalid slots, i.e. 0.
- Forwarding latency: the code is computed in cycle t from the ID instruction. It appears on fwd_a/fwd_b in cycle t+1, while that instruction is in EX.
- Load-use: one stall cycle per hazard.
  - Cycle t: stall=1, bubble=1.
  - Cycle t+1: the load is in MEM, so the dependent instruction recomputes and gets code 01. No second stall.
- A stall during a flush is suppressed; flush wins, and a bubble is inserted.
- Back-to-back writers to the same register: the EX-slot writer (code 10) is chosen over the MEM-slot writer.
- rs==rt with both used: fwd_a and fwd_b are both set identically.
- Reset deasserted mid-stream: the pipeline restarts empty, with no spurious stall in the first cycle.

## Test plan
- ALU dependency: cycle 0 ID=add r3 (regwrite); cycle 1 ID=sub reads rs=r3 -> cycle 2 fwd_a=10, fwd_b=00, stall never 1.
- Distance-2 dependency: add r4 at cycle 0, nop at cycle 1, or r4 as rt at cycle 2 -> cycle 3 fwd_b=01.
- Load-use: lw r5 at cycle 0, add reads r5 at cycle 1 -> cycle 1 stall=1, bubble=1. Cycle 2: stall=0, and the add is still in ID. Cycle 3: fwd_a=01. stall_cnt=1.
- Priority and r0: writers to r6 at cycles 0 and 1, reader of r6 at cycle 2 -> cycle 3 code 10. Writer to r0 followed by a reader of r0 -> code 00, no stall.
- Flush vs stall: lw r7 followed by a reader of r7 with flush=1 in the same cycle -> stall=0, bubble=1, stall_cnt unchanged.
- Async reset pulse mid-stream (between clock edges): outputs go to 00/0 immediately. Preload stall_cnt to all-ones and stall again -> the count holds at all-ones.
